dot_product_ctrl: RTL and testbench

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

---
 rtl/dot_product_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dot_product_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_ctrl.sv
// Dot-product job controller: streams matching elements out of SRAMs A and B,
// accumulates their products, and writes the sum into an output SRAM.
module dot_product_ctrl #(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int acc_width  = 2 * data_width + addr_width
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [addr_width-1:0] Base_Addr,
    input  logic [addr_width:0]   Length,
    input  logic [addr_width-1:0] Out_Addr,
    output logic                  Chip_Select_AB,
    output logic                  En_Read_AB,
    output logic [addr_width-1:0] Read_Addr_AB,
    input  logic [data_width-1:0] Read_Data_A,
    input  logic [data_width-1:0] Read_Data_B,
    output logic                  Out_Chip_Select,
    output logic                  Out_En_Write,
    output logic [addr_width-1:0] Out_Write_Addr,
    output logic [acc_width-1:0]  Out_Write_Data,
    output logic [acc_width-1:0]  Result,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [addr_width-1:0]   base_q, base_d;
    logic [addr_width:0]     len_q, len_d;
    logic [addr_width-1:0]   out_addr_q, out_addr_d;
    logic [addr_width:0]     idx_q, idx_d;
    logic [acc_width-1:0]    acc_q, acc_d;
    logic                    valid_q, valid_d;
    logic                    rd_q, rd_d;
    logic [addr_width-1:0]   rd_addr_q, rd_addr_d;
    logic                    wr_q, wr_d;
    logic [addr_width-1:0]   wr_addr_q, wr_addr_d;
    logic [acc_width-1:0]    wr_data_q, wr_data_d;
    logic [acc_width-1:0]    result_q, result_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [2*data_width-1:0] prod;

    // Outputs are registered from the next-state decision, so each output
    // register holds the value belonging to the state being entered.
    // idx_q counts reads already issued; the READ cycle that sees idx_q == len_q
    // issues nothing and hands over to DRAIN.
    always_comb begin
        prod       = Read_Data_A * Read_Data_B;
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        out_addr_d = out_addr_q;
        idx_d      = idx_q;
        acc_d      = valid_q ? acc_q + acc_width'(prod) : acc_q;
        valid_d    = rd_q;
        rd_d       = 1'b0;
        rd_addr_d  = '0;
        wr_d       = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    base_d     = Base_Addr;
                    len_d      = Length;
                    out_addr_d = Out_Addr;
                    acc_d      = '0;
                    idx_d      = '0;
                    if (Length != '0) begin
                        state_d   = ST_READ;
                        rd_d      = 1'b1;
                        rd_addr_d = Base_Addr;
                        idx_d     = (addr_width + 1)'(1);
                    end else begin
                        state_d   = ST_WRITE;
                        wr_d      = 1'b1;
                        wr_addr_d = Out_Addr;
                        wr_data_d = '0;
                        result_d  = '0;
                    end
                end
            end
            ST_READ: begin
                if (idx_q == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_d      = 1'b1;
                    rd_addr_d = base_q + idx_q[addr_width-1:0];
                    idx_d     = idx_q + (addr_width + 1)'(1);
                end
            end
            ST_DRAIN: begin
                state_d   = ST_WRITE;
                wr_d      = 1'b1;
                wr_addr_d = out_addr_q;
                wr_data_d = acc_d;
                result_d  = acc_d;
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, job registers and registered outputs; reset aborts any job.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            out_addr_q <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            valid_q    <= 1'b0;
            rd_q       <= 1'b0;
            rd_addr_q  <= '0;
            wr_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            out_addr_q <= out_addr_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            rd_addr_q  <= rd_addr_d;
            wr_q       <= wr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Chip_Select_AB  = rd_q;
    assign En_Read_AB      = rd_q;
    assign Read_Addr_AB    = rd_addr_q;
    assign Out_Chip_Select = wr_q;
    assign Out_En_Write    = wr_q;
    assign Out_Write_Addr  = wr_addr_q;
    assign Out_Write_Data  = wr_data_q;
    assign Result          = result_q;
    assign Busy            = busy_q;
    assign Done            = done_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl with behavioural SRAM A/B and a dot-product model.
module tb_dot_product_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int ACCW = 2 * DW + AW;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            Rst = 1'b1;
    logic            Start = 1'b0;
    logic [AW-1:0]   Base_Addr = '0;
    logic [AW:0]     Length = '0;
    logic [AW-1:0]   Out_Addr = '0;
    logic            Chip_Select_AB, En_Read_AB;
    logic [AW-1:0]   Read_Addr_AB;
    logic [DW-1:0]   Read_Data_A = '0;
    logic [DW-1:0]   Read_Data_B = '0;
    logic            Out_Chip_Select, Out_En_Write;
    logic [AW-1:0]   Out_Write_Addr;
    logic [ACCW-1:0] Out_Write_Data, Result;
    logic            Busy, Done;

    logic [DW-1:0]   mem_a [DEPTH];
    logic [DW-1:0]   mem_b [DEPTH];
    logic [ACCW-1:0] prev_result = '0;
    int              checks = 0;
    int              errors = 0;

    dot_product_ctrl #(.data_width(DW), .addr_width(AW), .acc_width(ACCW)) dut (
        .clk(clk), .Rst(Rst), .Start(Start), .Base_Addr(Base_Addr), .Length(Length),
        .Out_Addr(Out_Addr), .Chip_Select_AB(Chip_Select_AB), .En_Read_AB(En_Read_AB),
        .Read_Addr_AB(Read_Addr_AB), .Read_Data_A(Read_Data_A), .Read_Data_B(Read_Data_B),
        .Out_Chip_Select(Out_Chip_Select), .Out_En_Write(Out_En_Write),
        .Out_Write_Addr(Out_Write_Addr), .Out_Write_Data(Out_Write_Data),
        .Result(Result), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM pair
    always @(posedge clk) begin
        if (Chip_Select_AB && En_Read_AB) begin
            Read_Data_A <= mem_a[Read_Addr_AB];
            Read_Data_B <= mem_b[Read_Addr_AB];
        end
    end

    function automatic logic [ACCW-1:0] model_dot(input int unsigned base, input int unsigned len);
        int unsigned sum = 0;
        for (int unsigned i = 0; i < len; i++)
            sum += int'(mem_a[(base + i) % DEPTH]) * int'(mem_b[(base + i) % DEPTH]);
        return ACCW'(sum);
    endfunction

    task automatic fill_random();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_a[i] = DW'($urandom_range(0, 255));
            mem_b[i] = DW'($urandom_range(0, 255));
        end
    endtask

    // Start a job in cycle 0 and check every output in cycles 1 .. DONE+1.
    // With restart set, a second Start with other parameters lands in cycle 2.
    task automatic run_job(input int unsigned base, input int unsigned len,
                           input int unsigned oaddr, input bit restart);
        logic [ACCW-1:0] want;
        int unsigned     wr_c;
        logic            exp_rd, exp_wr, exp_done, exp_busy;
        logic [AW-1:0]   exp_addr, exp_waddr;
        logic [ACCW-1:0] exp_wdata, exp_res;
        want = model_dot(base, len);
        wr_c = (len == 0) ? 1 : len + 2;
        @(negedge clk);
        Start = 1'b1; Base_Addr = AW'(base); Length = (AW + 1)'(len); Out_Addr = AW'(oaddr);
        for (int unsigned c = 1; c <= wr_c + 2; c++) begin
            @(negedge clk);
            Start = 1'b0;
            if (restart && c == 2) begin
                Start = 1'b1; Base_Addr = AW'(base + 5); Length = (AW + 1)'(1);
                Out_Addr = AW'(oaddr + 1);
            end
            exp_rd    = (c >= 1 && c <= len);
            exp_addr  = exp_rd ? AW'((base + c - 1) % DEPTH) : '0;
            exp_wr    = (c == wr_c);
            exp_waddr = exp_wr ? AW'(oaddr) : '0;
            exp_wdata = exp_wr ? want : '0;
            exp_done  = (c == wr_c + 1);
            exp_busy  = (c <= wr_c + 1);
            exp_res   = (c >= wr_c) ? want : prev_result;
            checks++;
            if ({Chip_Select_AB, En_Read_AB, Read_Addr_AB} !== {exp_rd, exp_rd, exp_addr}) begin
                errors++;
                $display("FAIL read c%0d base%0d len%0d: cs=%b en=%b addr=%0d want cs/en=%b addr=%0d",
                         c, base, len, Chip_Select_AB, En_Read_AB, Read_Addr_AB, exp_rd, exp_addr);
            end
            checks++;
            if ({Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data} !==
                {exp_wr, exp_wr, exp_waddr, exp_wdata}) begin
                errors++;
                $display("FAIL write c%0d: cs=%b we=%b addr=%0d data=%0d want we=%b addr=%0d data=%0d",
                         c, Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data,
                         exp_wr, exp_waddr, exp_wdata);
            end
            checks++;
            if ({Done, Busy} !== {exp_done, exp_busy}) begin
                errors++;
                $display("FAIL done_busy c%0d: done=%b busy=%b want done=%b busy=%b",
                         c, Done, Busy, exp_done, exp_busy);
            end
            checks++;
            if (Result !== exp_res) begin
                errors++;
                $display("FAIL result c%0d: got %0d want %0d", c, Result, exp_res);
            end
        end
        prev_result = want;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({Chip_Select_AB, En_Read_AB, Read_Addr_AB, Out_Chip_Select, Out_En_Write,
             Out_Write_Addr, Out_Write_Data, Result, Busy, Done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b cs=%b we=%b result=%0d want all 0",
                     Busy, Done, Chip_Select_AB, Out_En_Write, Result);
        end
        Rst = 1'b0; Start = 1'b0;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_start: busy=%b want 0", Busy);
        end
        prev_result = '0;
    endtask

    task automatic test_basic();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0; mem_b[i] = '0;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1); mem_b[i] = DW'(i + 5);
        end
        run_job(0, 4, 3, 1'b0);
    endtask

    task automatic test_full_scale();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_a[i] = 8'hFF; mem_b[i] = 8'hFF;
        end
        run_job(0, 16, 9, 1'b0);
    endtask

    task automatic test_wrap();
        fill_random();
        run_job(14, 4, 2, 1'b0);
        run_job(9, 16, 11, 1'b0);
    endtask

    task automatic test_zero_length();
        run_job(3, 0, 5, 1'b0);
    endtask

    task automatic test_start_while_busy();
        fill_random();
        run_job(1, 4, 7, 1'b1);
    endtask

    task automatic test_abort();
        fill_random();
        @(negedge clk);
        Start = 1'b1; Base_Addr = 4'd0; Length = 5'd4; Out_Addr = 4'd6;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        Rst = 1'b0;
        checks++;
        if ({Busy, Chip_Select_AB, Result} !== '0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b cs=%b result=%0d want 0", Busy, Chip_Select_AB, Result);
        end
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({Out_En_Write, Done} !== 2'b00) begin
                errors++;
                $display("FAIL abort_quiet: we=%b done=%b want 0", Out_En_Write, Done);
            end
        end
        prev_result = '0;
        run_job(2, 4, 6, 1'b0);
    endtask

    task automatic test_random();
        for (int unsigned j = 0; j < 20; j++) begin
            if (j % 4 == 0) fill_random();
            run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                    $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_wrap();
        test_zero_length();
        test_start_while_busy();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
